// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states,
// ALU control codes, data-processing commands, condition codes, flag indices.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_UNDEF  = 4'd10
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;
  localparam logic [2:0] ALU_MUL = 3'd5;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/mc_condlogic.sv
// Flags register, per-instruction CondEx latch, ARM condition evaluation
// and the conditional gating of the datapath write enables.
module mc_condlogic
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flagw,
  input  logic       flag_en,
  input  logic       cond_latch,
  input  logic       regw,
  input  logic       memw,
  input  logic       branch,
  input  logic       nextpc,
  input  logic       rd_pc,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite
);

  logic [3:0] flags;
  logic       condex;

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, ge, r;
    n  = f[FLAG_N];
    z  = f[FLAG_Z];
    cy = f[FLAG_C];
    v  = f[FLAG_V];
    ge = (n == v);
    case (c)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = cy;
      COND_CC: r = ~cy;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = cy & ~z;
      COND_LS: r = ~cy | z;
      COND_GE: r = ge;
      COND_LT: r = ~ge;
      COND_GT: r = ~z & ge;
      COND_LE: r = z | ~ge;
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // CondEx is frozen at DECODE so a flag write in EXEC cannot change the
  // outcome of the instruction that produced it.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags  <= '0;
      condex <= 1'b0;
    end else begin
      if (cond_latch)
        condex <= cond_eval(cond, flags);
      if (flag_en && condex) begin
        if (flagw[1]) begin
          flags[FLAG_N] <= alu_flags[FLAG_N];
          flags[FLAG_Z] <= alu_flags[FLAG_Z];
        end
        if (flagw[0]) begin
          flags[FLAG_C] <= alu_flags[FLAG_C];
          flags[FLAG_V] <= alu_flags[FLAG_V];
        end
      end
    end
  end

  always_comb begin
    regwrite = ~reset & regw & condex;
    memwrite = ~reset & memw & condex;
    pcwrite  = ~reset & (nextpc | (condex & (branch | (regw & rd_pc))));
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM-subset control unit: main FSM, instruction/ALU decode and
// datapath select generation; conditional gating lives in mc_condlogic.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter bit MEM_WAIT   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Instr,
  input  logic [3:0]            ALUFlags,
  input  logic                  MemReady,
  output logic                  PCWrite,
  output logic                  MemWrite,
  output logic                  RegWrite,
  output logic                  IRWrite,
  output logic                  AdrSrc,
  output logic                  ALUSrcA,
  output logic [1:0]            RegSrc,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  Undef,
  output logic [3:0]            state
);

  localparam bit HAS_EXT = (ALU_CTRL_W >= 3);

  state_t     st, dst;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic       sbit, is_mul, is_cmp, dp_ok, ready, rd_pc;
  logic [2:0] dp_alu, alu_sel;
  logic [1:0] flagw;
  logic       irw, nextpc, regw, memw, branch, flag_en, cond_latch;
  logic       unused_instr;

  assign op           = Instr[27:26];
  assign funct        = Instr[25:20];
  assign cmd          = funct[4:1];
  assign sbit         = funct[0];
  assign rd_pc        = (Instr[15:12] == 4'hF);
  assign is_mul       = (op == OP_DP) && (funct[5:1] == 5'b00000) && (Instr[7:4] == 4'b1001);
  assign is_cmp       = !is_mul && (cmd == CMD_CMP) && sbit;
  assign ready        = MEM_WAIT ? MemReady : 1'b1;
  assign unused_instr = ^{Instr[19:16], Instr[11:8], Instr[3:0]};

  always_comb begin
    dp_alu = ALU_ADD;
    dp_ok  = 1'b1;
    flagw  = 2'b00;
    if (is_mul) begin
      dp_alu = ALU_MUL;
      dp_ok  = HAS_EXT;
    end else begin
      case (cmd)
        CMD_ADD: dp_alu = ALU_ADD;
        CMD_SUB: dp_alu = ALU_SUB;
        CMD_AND: dp_alu = ALU_AND;
        CMD_ORR: dp_alu = ALU_ORR;
        CMD_EOR: begin
          dp_alu = ALU_EOR;
          dp_ok  = HAS_EXT;
        end
        CMD_CMP: begin
          dp_alu = ALU_SUB;
          dp_ok  = sbit;
        end
        default: dp_ok = 1'b0;
      endcase
    end
    if (sbit)
      flagw = (dp_alu == ALU_ADD || dp_alu == ALU_SUB) ? 2'b11 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= S_FETCH;
      Undef <= 1'b0;
    end else begin
      case (st)
        S_FETCH:  if (ready) st <= S_DECODE;
        S_DECODE: begin
          if (op == OP_MEM)
            st <= S_MEMADR;
          else if (op == OP_BR)
            st <= S_BRANCH;
          else if (op == OP_DP && dp_ok)
            st <= funct[5] ? S_EXECI : S_EXECR;
          else begin
            st    <= S_UNDEF;
            Undef <= 1'b1;
          end
        end
        S_MEMADR:         st <= funct[0] ? S_MEMRD : S_MEMWR;
        S_MEMRD:          if (ready) st <= S_MEMWB;
        S_MEMWR:          if (ready) st <= S_FETCH;
        S_EXECR, S_EXECI: st <= is_cmp ? S_FETCH : S_ALUWB;
        default:          st <= S_FETCH;
      endcase
    end
  end

  // While reset is held the selects present the FETCH view of the datapath.
  assign dst = reset ? S_FETCH : st;

  always_comb begin
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    alu_sel    = ALU_ADD;
    irw        = 1'b0;
    nextpc     = 1'b0;
    regw       = 1'b0;
    memw       = 1'b0;
    branch     = 1'b0;
    flag_en    = 1'b0;
    cond_latch = 1'b0;
    case (dst)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irw       = ready;
        nextpc    = ready;
      end
      S_DECODE: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        cond_latch = 1'b1;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        regw      = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        memw   = 1'b1;
      end
      S_EXECR: begin
        alu_sel = dp_alu;
        flag_en = 1'b1;
      end
      S_EXECI: begin
        ALUSrcB = 2'b01;
        alu_sel = dp_alu;
        flag_en = 1'b1;
      end
      S_ALUWB:  regw = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign IRWrite    = irw & ~reset;
  assign ALUControl = alu_sel[ALU_CTRL_W-1:0];
  assign RegSrc     = {op == OP_MEM, op == OP_BR};
  assign ImmSrc     = op;
  assign state      = st;

  mc_condlogic u_cond (
    .clk        (clk),
    .reset      (reset),
    .cond       (Instr[31:28]),
    .alu_flags  (ALUFlags),
    .flagw      (flagw),
    .flag_en    (flag_en),
    .cond_latch (cond_latch),
    .regw       (regw),
    .memw       (memw),
    .branch     (branch),
    .nextpc     (nextpc),
    .rd_pc      (rd_pc),
    .pcwrite    (PCWrite),
    .regwrite   (RegWrite),
    .memwrite   (MemWrite)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a 3-bit ALU-control instance plus a
// 2-bit instance run in lockstep to cover the reduced ALU op set.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;

  logic       pcwrite, memwrite, regwrite, irwrite, adrsrc, alusrca, undef;
  logic [1:0] regsrc, alusrcb, resultsrc, immsrc;
  logic [2:0] aluctl;
  logic [3:0] st;

  logic       pcwrite2, memwrite2, regwrite2, undef2;
  logic [1:0] aluctl2;
  logic [3:0] st2;
  logic       irwrite2_unused, adrsrc2_unused, alusrca2_unused;
  logic [1:0] regsrc2_unused, alusrcb2_unused, resultsrc2_unused, immsrc2_unused;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.ALU_CTRL_W(3), .MEM_WAIT(1'b1)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(pcwrite), .MemWrite(memwrite), .RegWrite(regwrite), .IRWrite(irwrite),
    .AdrSrc(adrsrc), .ALUSrcA(alusrca), .RegSrc(regsrc), .ALUSrcB(alusrcb),
    .ResultSrc(resultsrc), .ImmSrc(immsrc), .ALUControl(aluctl), .Undef(undef), .state(st)
  );

  multicycle_ctrl #(.ALU_CTRL_W(2), .MEM_WAIT(1'b1)) dut2 (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(pcwrite2), .MemWrite(memwrite2), .RegWrite(regwrite2), .IRWrite(irwrite2_unused),
    .AdrSrc(adrsrc2_unused), .ALUSrcA(alusrca2_unused), .RegSrc(regsrc2_unused),
    .ALUSrcB(alusrcb2_unused), .ResultSrc(resultsrc2_unused), .ImmSrc(immsrc2_unused),
    .ALUControl(aluctl2), .Undef(undef2), .state(st2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; MemReady = 1'b1; ALUFlags = 4'h0; Instr = 32'hE0812003;
    step(); step(); #1;
    n_checks++; if (st !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", st); end
    n_checks++; if (undef !== 1'b0) begin n_fail++; $display("FAIL reset_undef: got %b want 0", undef); end
    n_checks++; if (irwrite !== 1'b0) begin n_fail++; $display("FAIL reset_irwrite: got %b want 0", irwrite); end
    n_checks++; if (pcwrite !== 1'b0) begin n_fail++; $display("FAIL reset_pcwrite: got %b want 0", pcwrite); end
    n_checks++; if ({alusrca, alusrcb, resultsrc, adrsrc} !== 6'b1_10_10_0) begin n_fail++; $display("FAIL reset_selects: got %b want 110100", {alusrca, alusrcb, resultsrc, adrsrc}); end
    n_checks++; if (aluctl !== 3'd0) begin n_fail++; $display("FAIL reset_aluctl: got %0d want 0", aluctl); end
    reset = 1'b0; MemReady = 1'b0; #1;
    n_checks++; if (irwrite !== 1'b0) begin n_fail++; $display("FAIL fetch_wait_irwrite: got %b want 0", irwrite); end
    step(); #1;
    n_checks++; if (st !== 4'd0) begin n_fail++; $display("FAIL fetch_wait_hold: got %0d want 0", st); end
  endtask

  task automatic test_add();
    Instr = 32'hE0812003; MemReady = 1'b1; #1;
    n_checks++; if ({irwrite, pcwrite, regwrite} !== 3'b110) begin n_fail++; $display("FAIL add_fetch_en: got %b want 110", {irwrite, pcwrite, regwrite}); end
    step();
    n_checks++; if ({st, irwrite, pcwrite} !== {4'd1, 2'b00}) begin n_fail++; $display("FAIL add_decode: got %0d/%b want 1/00", st, {irwrite, pcwrite}); end
    step();
    n_checks++; if (st !== 4'd6) begin n_fail++; $display("FAIL add_execr_state: got %0d want 6", st); end
    n_checks++; if ({aluctl, alusrca, alusrcb, regwrite} !== {3'd0, 1'b0, 2'b00, 1'b0}) begin n_fail++; $display("FAIL add_execr_ctl: got %b want 0000000", {aluctl, alusrca, alusrcb, regwrite}); end
    n_checks++; if (aluctl2 !== 2'd0) begin n_fail++; $display("FAIL add_execr_aluctl_w2: got %0d want 0", aluctl2); end
    step();
    n_checks++; if ({st, regwrite, resultsrc, pcwrite} !== {4'd8, 1'b1, 2'b00, 1'b0}) begin n_fail++; $display("FAIL add_aluwb: got %0d/%b want 8/1000", st, {regwrite, resultsrc, pcwrite}); end
    step();
    Instr = 32'hE081F003;
    step(); step(); step();
    n_checks++; if ({st, regwrite, pcwrite} !== {4'd8, 2'b11}) begin n_fail++; $display("FAIL add_pc_dest: got %0d/%b want 8/11", st, {regwrite, pcwrite}); end
    step();
  endtask

  task automatic test_subs_beq();
    Instr = 32'hE0512003; ALUFlags = 4'b0100;
    step(); step(); #1;
    n_checks++; if ({st, aluctl} !== {4'd6, 3'd1}) begin n_fail++; $display("FAIL subs_execr: got %0d/%0d want 6/1", st, aluctl); end
    step(); step();
    Instr = 32'h0A000002; ALUFlags = 4'b0000;
    step(); #1;
    n_checks++; if ({regsrc, immsrc} !== 4'b01_10) begin n_fail++; $display("FAIL beq_decode_src: got %b want 0110", {regsrc, immsrc}); end
    step();
    n_checks++; if ({st, pcwrite, alusrcb, resultsrc} !== {4'd9, 1'b1, 2'b01, 2'b10}) begin n_fail++; $display("FAIL beq_taken: got %0d/%b want 9/10110", st, {pcwrite, alusrcb, resultsrc}); end
    n_checks++; if (pcwrite2 !== 1'b1) begin n_fail++; $display("FAIL beq_taken_w2: got %b want 1", pcwrite2); end
    step();
    Instr = 32'hE0512003; ALUFlags = 4'b0000;
    step(); step(); step(); step();
    Instr = 32'h0A000002;
    step(); step();
    n_checks++; if ({st, pcwrite} !== {4'd9, 1'b0}) begin n_fail++; $display("FAIL beq_not_taken: got %0d/%b want 9/0", st, pcwrite); end
    step();
  endtask

  task automatic test_ldr_wait();
    Instr = 32'hE5912000; MemReady = 1'b1;
    step(); #1;
    n_checks++; if ({st, regsrc, immsrc} !== {4'd1, 2'b10, 2'b01}) begin n_fail++; $display("FAIL ldr_decode: got %0d/%b want 1/1001", st, {regsrc, immsrc}); end
    step();
    n_checks++; if ({st, alusrca, alusrcb, aluctl} !== {4'd2, 1'b0, 2'b01, 3'd0}) begin n_fail++; $display("FAIL ldr_memadr: got %0d/%b want 2/001000", st, {alusrca, alusrcb, aluctl}); end
    step();
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if ({st, adrsrc, regwrite} !== {4'd3, 2'b10}) begin n_fail++; $display("FAIL ldr_memrd_wait%0d: got %0d/%b want 3/10", i, st, {adrsrc, regwrite}); end
      step();
    end
    MemReady = 1'b1; #1;
    n_checks++; if (st !== 4'd3) begin n_fail++; $display("FAIL ldr_memrd_ready: got %0d want 3", st); end
    step();
    n_checks++; if ({st, resultsrc, regwrite} !== {4'd4, 2'b01, 1'b1}) begin n_fail++; $display("FAIL ldr_memwb: got %0d/%b want 4/011", st, {resultsrc, regwrite}); end
    step();
    n_checks++; if (st !== 4'd0) begin n_fail++; $display("FAIL ldr_back_to_fetch: got %0d want 0", st); end
  endtask

  task automatic test_cmp_flags();
    Instr = 32'hE1510002; ALUFlags = 4'b0110;
    step(); step(); #1;
    n_checks++; if ({st, aluctl, regwrite} !== {4'd6, 3'd1, 1'b0}) begin n_fail++; $display("FAIL cmp_execr: got %0d/%0d/%b want 6/1/0", st, aluctl, regwrite); end
    step();
    n_checks++; if (st !== 4'd0) begin n_fail++; $display("FAIL cmp_three_cycles: got %0d want 0", st); end
    Instr = 32'h0A000002; ALUFlags = 4'b0000;
    step(); step();
    n_checks++; if ({st, pcwrite} !== {4'd9, 1'b1}) begin n_fail++; $display("FAIL cmp_sets_z: got %0d/%b want 9/1", st, pcwrite); end
    step();
    Instr = 32'hE0112003;
    step(); step(); #1;
    n_checks++; if (aluctl !== 3'd2) begin n_fail++; $display("FAIL ands_aluctl: got %0d want 2", aluctl); end
    step(); step();
    Instr = 32'h0A000002;
    step(); step();
    n_checks++; if (pcwrite !== 1'b0) begin n_fail++; $display("FAIL ands_clears_z: got %b want 0", pcwrite); end
    step();
    Instr = 32'h2A000002;
    step(); step();
    n_checks++; if (pcwrite !== 1'b1) begin n_fail++; $display("FAIL ands_keeps_c: got %b want 1", pcwrite); end
    step();
  endtask

  task automatic test_mul_eor();
    Instr = 32'hE0000291; ALUFlags = 4'b0000; MemReady = 1'b1;
    step(); step(); #1;
    n_checks++; if ({st, aluctl} !== {4'd6, 3'd5}) begin n_fail++; $display("FAIL mul_aluctl: got %0d/%0d want 6/5", st, aluctl); end
    n_checks++; if ({st2, undef2} !== {4'd10, 1'b1}) begin n_fail++; $display("FAIL mul_w2_undef: got %0d/%b want 10/1", st2, undef2); end
    n_checks++; if ({regwrite2, pcwrite2, memwrite2} !== 3'b000) begin n_fail++; $display("FAIL mul_w2_no_en: got %b want 000", {regwrite2, pcwrite2, memwrite2}); end
    n_checks++; if (undef !== 1'b0) begin n_fail++; $display("FAIL mul_w3_no_undef: got %b want 0", undef); end
    step();
    MemReady = 1'b0;
    step();
    MemReady = 1'b1; #1;
    n_checks++; if ({st, st2, undef2} !== {4'd0, 4'd0, 1'b1}) begin n_fail++; $display("FAIL undef_sticky: got %0d/%0d/%b want 0/0/1", st, st2, undef2); end
    Instr = 32'hE0212003;
    step(); step(); #1;
    n_checks++; if ({st, aluctl} !== {4'd6, 3'd4}) begin n_fail++; $display("FAIL eor_aluctl: got %0d/%0d want 6/4", st, aluctl); end
    n_checks++; if (st2 !== 4'd10) begin n_fail++; $display("FAIL eor_w2_undef: got %0d want 10", st2); end
    step();
    MemReady = 1'b0;
    step();
    MemReady = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0; #1;
    n_checks++; if ({st, st2, undef2} !== {4'd0, 4'd0, 1'b0}) begin n_fail++; $display("FAIL undef_reset_clear: got %0d/%0d/%b want 0/0/0", st, st2, undef2); end
  endtask

  task automatic test_cond_nv();
    Instr = 32'hF0812003; ALUFlags = 4'b0000;
    step(); step(); step(); #1;
    n_checks++; if ({st, regwrite} !== {4'd8, 1'b0}) begin n_fail++; $display("FAIL cond_nv_no_write: got %0d/%b want 8/0", st, regwrite); end
    step();
  endtask

  task automatic test_reset_memwr();
    Instr = 32'hE1510002; ALUFlags = 4'b0100;
    step(); step(); step();
    Instr = 32'hE5812000; ALUFlags = 4'b0000;
    step(); step(); step();
    MemReady = 1'b0; #1;
    n_checks++; if ({st, memwrite, adrsrc} !== {4'd5, 2'b11}) begin n_fail++; $display("FAIL str_memwr_wait: got %0d/%b want 5/11", st, {memwrite, adrsrc}); end
    step();
    reset = 1'b1; #1;
    n_checks++; if ({st, memwrite, adrsrc} !== {4'd5, 2'b00}) begin n_fail++; $display("FAIL str_reset_cycle: got %0d/%b want 5/00", st, {memwrite, adrsrc}); end
    step();
    n_checks++; if (st !== 4'd0) begin n_fail++; $display("FAIL str_reset_next: got %0d want 0", st); end
    reset = 1'b0; MemReady = 1'b1; Instr = 32'h0A000002;
    step(); step();
    n_checks++; if ({st, pcwrite} !== {4'd9, 1'b0}) begin n_fail++; $display("FAIL reset_clears_flags: got %0d/%b want 9/0", st, pcwrite); end
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_subs_beq();
    test_ldr_wait();
    test_cmp_flags();
    test_mul_eor();
    test_cond_nv();
    test_reset_memwr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised control unit for the multicycle ARM-subset processor. It combines the main instruction FSM, ALU/flag decode and conditional-execution logic in one block. Over the previous controller it adds a memory-ready wait handshake, an EOR/MUL-capable ALU control field, CMP (flags-only) handling, and a sticky undefined-instruction indicator. It drives the datapath enables and selects directly.

## Interface
- ALU_CTRL_W, 3, ALUControl width; legal values are 2 or 3. With 2, EOR and MUL are undefined.
- MEM_WAIT, 1, 1 = honour MemReady; 0 = MemReady is ignored and treated as 1.
- clk  in  1  sole clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high.
- Instr  in  32  current instruction register contents.
- ALUFlags  in  4  {N,Z,C,V} from the ALU.
- MemReady  in  1  memory has completed the current access this cycle.
- PCWrite, MemWrite, RegWrite, IRWrite  out  1 each  write enables.
- AdrSrc, ALUSrcA  out  1 each  mux selects.
- RegSrc, ALUSrcB, ResultSrc, ImmSrc  out  2 each  mux selects.
- ALUControl  out  ALU_CTRL_W  encoding: ADD=0, SUB=1, AND=2, ORR=3, EOR=4, MUL=5.
- Undef  out  1  sticky; set by any undefined instruction.
- state  out  4  current FSM state, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, UNDEF 10.
- Field names: Op=Instr[27:26], Funct=Instr[25:20], Rd=Instr[15:12], Cond=Instr[31:28].
- MUL is recognised when Op=00, Funct[5:1]=00000 and Instr[7:4]=1001.
- **FETCH:** AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - IRWrite and PC increment are asserted only when ready (MemReady, or MEM_WAIT=0).
  - Not ready: stay in FETCH. Ready: go to DECODE.
- **DECODE:** ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Latches CondEx. Next state:
  - Op=01 → MEMADR.
  - Op=10 → BRANCH.
  - Op=00 with Funct[5]=1 → EXECI.
  - Op=00 with Funct[5]=0 → EXECR.
  - Unsupported opcode, or Op=11 → UNDEF.
- **MEMADR:** ALUSrcA=0, ALUSrcB=01, ADD. Funct[0]=1 (load) → MEMRD; otherwise → MEMWR.
- **MEMRD:** AdrSrc=1. Hold until ready, then → MEMWB.
- **MEMWB:** ResultSrc=01, RegW. Then → FETCH.
- **MEMWR:** AdrSrc=1. MemWrite is held high while waiting (gated by CondEx). On ready → FETCH.
- **EXECR / EXECI:** ALUSrcA=0; ALUSrcB=00 (EXECR) or 01 (EXECI); ALU op from Funct[4:1].
  - CMP (Funct[4:1]=1010 with S=1) → FETCH.
  - Everything else → ALUWB.
- **ALUWB:** ResultSrc=00, RegW. Then → FETCH.
- **BRANCH:** ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch. Then → FETCH.
- **UNDEF:** no write enables asserted. Sets Undef. Then → FETCH, so the instruction is skipped.
- **Combinational outputs:** RegSrc[0]=(Op==10), RegSrc[1]=(Op==01), ImmSrc=Op.
- **FlagW:**
  - S=0 → 00.
  - ADD/SUB/CMP with S=1 → 11.
  - AND/ORR/EOR/MUL with S=1 → 10.
- **Flags update:** at the end of EXECR/EXECI when CondEx is set. FlagW[1] writes N,Z; FlagW[0] writes C,V.
- **CondEx:** full ARM condition evaluation (EQ..AL, 15 codes) against the stored flags. Latched at the DECODE edge and used for the whole instruction.
  - Code 1111 evaluates as false.
- **Gated enables:**
  - RegWrite = RegW & CondEx.
  - MemWrite = MemW & CondEx.
  - PCWrite = NextPC | (CondEx & (Branch | (RegW & Rd==15))).

## Timing
- **Reset (synchronous):** state=FETCH, Flags=0, CondEx=0, Undef=0.
  - While reset is high, PCWrite, MemWrite, RegWrite and IRWrite are forced to 0.
  - Selects show the FETCH values.
- **Cycle counts with zero wait** (including FETCH):
  - 3 cycles: BRANCH, CMP, UNDEF.
  - 4 cycles: data-processing, STR.
  - 5 cycles: LDR.
- Each cycle MemReady is low in FETCH, MEMRD or MEMWR adds one cycle. There is no timeout.
- A flag write in EXECR/EXECI is visible to the next instruction's DECODE latch.
- Reset asserted mid-instruction (including during a wait) aborts on that edge; no enables are asserted in that cycle.
- Undef is cleared only by reset.

## Structure
- Package mc_ctrl_pkg holds: the state encodings, ALU op codes, condition-code constants and the flag bit indices.
- One sub-module, mc_condlogic, holds the flags register, the CondEx latch, condition evaluation and enable gating.
- The FSM and the decoders stay in the top module.

## Test plan
- **ADD reg, zero wait (Instr=E0812003):** cycles FETCH→DECODE→EXECR→ALUWB.
  - RegWrite=1 only in ALUWB.
  - ALUControl=0 in EXECR.
- **SUBS then BEQ:** SUBS with ALUFlags=0100 sets Z.
  - The following 0A000002 asserts PCWrite in BRANCH.
  - Repeat with Z=0: no PCWrite in BRANCH.
- **LDR with MEM_WAIT=1:** MemReady low for 3 cycles in MEMRD.
  - state holds at 3 for 3 cycles.
  - MEMWB is reached on the 4th cycle; total 8 cycles.
- **CMP (E1510002):** 3 states (FETCH, DECODE, EXECR), no RegWrite, FlagW=11 updates flags.
- **MUL and EOR:**
  - ALU_CTRL_W=3: ALUControl=5 and 4.
  - ALU_CTRL_W=2: UNDEF is entered and Undef goes to 1.
- **Reset asserted during a MEMWR wait:** next state=FETCH, MemWrite=0 that cycle, Flags=0.
